// File: rtl/adder_bist.sv
// adder_bist: exhaustive built-in self-test for full_adder / W-bit ripple adders.
// Sweeps every {a,b,cin} vector into the adder under test, checks each response
// against a golden a+b+cin after DUT_LAT cycles, and reports errors and the first failure.
//
// state | meaning
// IDLE  | after reset; outputs held at 0, waiting for start
// RUN   | driving one vector per cycle, index 0 .. 2^(2W+1)-1
// DRAIN | last vector driven; waiting DUT_LAT+1 cycles for in-flight responses
// DONE  | results held until the next start or rst
module adder_bist #(
    parameter int W       = 1,
    parameter int DUT_LAT = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    output logic [W-1:0]   dut_a,
    output logic [W-1:0]   dut_b,
    output logic           dut_cin,
    input  logic [W-1:0]   dut_sum,
    input  logic           dut_cout,
    output logic           busy,
    output logic           done,
    output logic           pass,
    output logic [15:0]    err_cnt,
    output logic [2*W:0]   first_fail
);

    localparam int VW = 2 * W + 1;
    localparam logic [VW-1:0] V_LAST = '1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state;
    logic [2:0] drain_cnt;

    // Stage 0 is the register that drives the adder; later stages only delay the
    // {valid, vector} pair so it lines up with the adder's registered response.
    logic [DUT_LAT:0][VW:0] pipe;

    logic [VW:0]   tap;
    logic          tap_valid;
    logic [W-1:0]  tap_a;
    logic [W-1:0]  tap_b;
    logic          tap_cin;
    logic [W:0]    expected;
    logic          mismatch;

    assign dut_a   = pipe[0][VW-1 -: W];
    assign dut_b   = pipe[0][W:1];
    assign dut_cin = pipe[0][0];

    // Golden model on the delayed vector; X/Z in the response counts as a mismatch.
    always_comb begin
        tap       = pipe[DUT_LAT];
        tap_valid = tap[VW];
        tap_a     = tap[VW-1 -: W];
        tap_b     = tap[W:1];
        tap_cin   = tap[0];
        expected  = {1'b0, tap_a} + {1'b0, tap_b} + {{W{1'b0}}, tap_cin};
        mismatch  = tap_valid && ({dut_cout, dut_sum} !== expected);
    end

    // Sweep sequencing, response pipeline and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pipe       <= '0;
            drain_cnt  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_cnt    <= '0;
            first_fail <= '0;
        end else begin
            for (int i = 1; i <= DUT_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end

            if (mismatch) begin
                if (err_cnt != 16'hFFFF) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                if (err_cnt == 16'd0) begin
                    first_fail <= tap[VW-1:0];
                end
            end

            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state      <= RUN;
                        pipe[0]    <= {1'b1, {VW{1'b0}}};
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_cnt    <= '0;
                        first_fail <= '0;
                    end
                end
                RUN: begin
                    if (pipe[0][VW-1:0] == V_LAST) begin
                        // Last vector stays on the bus but is no longer marked valid.
                        state       <= DRAIN;
                        pipe[0][VW] <= 1'b0;
                        drain_cnt   <= 3'(DUT_LAT);
                    end else begin
                        pipe[0] <= {1'b1, pipe[0][VW-1:0] + 1'b1};
                    end
                end
                DRAIN: begin
                    if (drain_cnt == 3'd0) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_cnt == 16'd0);
                    end else begin
                        drain_cnt <= drain_cnt - 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
Synthesizable built-in self-test engine for the adder family (full_adder and W-bit ripple adders). It drives every input combination into an adder under test, then collects and checks the adder's sum/carry responses against an internal golden model. It counts mismatches, records the first failing vector and reports pass/fail. It sits beside the adder in the lab/FPGA top and replaces hand-written stimulus with an on-chip exhaustive sweep plus response checker.

Parameters:
W, 1, operand width of the adder under test (1 = single full_adder); legal 1..8
DUT_LAT, 0, registered latency of the adder under test in cycles (0 = combinational); legal 0..4

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse that begins a sweep; ignored unless state is IDLE or DONE
dut_a  output  W  operand a to adder under test (registered)
dut_b  output  W  operand b to adder under test (registered)
dut_cin  output  1  carry-in to adder under test (registered)
dut_sum  input  W  sum returned by adder under test
dut_cout  input  1  carry-out returned by adder under test
busy  output  1  high in RUN and DRAIN
done  output  1  high in DONE until next start or rst
pass  output  1  valid when done; 1 iff err_cnt == 0
err_cnt  output  16  mismatch count, saturates at 16'hFFFF
first_fail  output  2W+1  vector index {a,b,cin} of first mismatch (cin = LSB); 0 when none

Behaviour:
- Reset (sync, rst high at an edge): state=IDLE. dut_a/dut_b/dut_cin=0, busy=0, done=0, pass=0, err_cnt=0, first_fail=0, and all pipeline valid bits cleared. rst overrides start in the same cycle. rst mid-sweep aborts immediately. No partial result is retained.
- Vector space: N = 2^(2W+1). Index v is an internal (2W+1)-bit counter. {dut_a,dut_b,dut_cin} = v, so cin is the LSB and a occupies the MSBs.
- States:
  - IDLE: outputs held at 0.
  - RUN: drive one vector per cycle.
  - DRAIN: wait for in-flight responses.
  - DONE: hold results.
- Transitions:
  - IDLE or DONE, with start high at edge e → RUN. At that edge: err_cnt=0, first_fail=0, done=0, pass=0, v=0 driven.
  - RUN: v increments each edge. Vector k is driven from edge e+k. After v=N-1 is driven → DRAIN. The counter does not wrap into a second sweep.
  - DRAIN lasts DUT_LAT+1 cycles, then → DONE. At edge e+N+DUT_LAT+1: done=1, busy=0, pass=(err_cnt==0), including the final compare.
  - start during RUN or DRAIN is ignored.
- Check pipeline:
  - The vector driven at edge t is carried through a valid+vector shift register of depth DUT_LAT+1.
  - dut_sum/dut_cout are sampled and compared at edge t+1+DUT_LAT.
  - Expected value: {cout,sum} = a + b + cin, computed at W+1 bits from the delayed vector.
- Mismatch:
  - err_cnt increments, saturating at 16'hFFFF.
  - If err_cnt was 0 before this compare, first_fail = delayed vector index.
  - first_fail never changes after the first mismatch of a sweep.
- Back-to-back sweeps: start in DONE restarts cleanly. Previous results clear at the restart edge.
- X/Z on the dut inputs is not filtered. A compare with unknown response is treated as a mismatch.

Test Plan:
- W=1, DUT_LAT=0, correct full_adder; rst 2 cycles, start pulse at edge e → dut vectors 0..7 on edges e..e+7; done=1 at e+9; pass=1; err_cnt=0; first_fail=0.
- W=1, DUT_LAT=0, full_adder with cout stuck-at-0 → err_cnt=4 (vectors 3,5,6,7); first_fail=3'b011; pass=0.
- W=1, sum output inverted → err_cnt=8; first_fail=0; pass=0. Second start pulse after done → err_cnt restarts at 0 and ends at 8 again.
- W=4, DUT_LAT=2, correct pipelined 4-bit adder → 512 vectors driven; done exactly at e+515; pass=1. Same bench with DUT_LAT=1 mismatch in the model → err_cnt>0, showing the latency alignment is checked.
- Reset mid-sweep: W=1, rst asserted at e+4 → next edge: busy=0, done=0, all outputs 0, state IDLE. start pulses during RUN (e+2) and in the same cycle as rst are ignored.
